// File: rtl/icache_refill_pkg.sv
// Cache geometry shared with the instruction cache, plus the line-refill FSM encoding.
package icache_refill_pkg;

    localparam int unsigned DEFAULT_CACHE_SIZE    = 1024;
    localparam int unsigned DEFAULT_BLOCK_SIZE    = 16;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 32;

    function automatic int unsigned offset_width(input int unsigned block_size);
        return 32'($clog2(block_size));
    endfunction

    function automatic int unsigned index_width(input int unsigned cache_size,
                                                input int unsigned block_size);
        return 32'($clog2(cache_size / block_size));
    endfunction

    function automatic int unsigned tag_width(input int unsigned address_width,
                                              input int unsigned cache_size,
                                              input int unsigned block_size);
        return address_width - offset_width(block_size) - index_width(cache_size, block_size);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FILL  = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill: fetches one line byte-by-byte from memory and
// writes the assembled line into the cache with a single fill_we pulse.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter  int unsigned CACHE_SIZE    = DEFAULT_CACHE_SIZE,
    parameter  int unsigned BLOCK_SIZE    = DEFAULT_BLOCK_SIZE,
    parameter  int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    localparam int unsigned OFFSET_WIDTH  = offset_width(BLOCK_SIZE),
    localparam int unsigned INDEX_WIDTH   = index_width(CACHE_SIZE, BLOCK_SIZE),
    localparam int unsigned TAG_WIDTH     = tag_width(ADDRESS_WIDTH, CACHE_SIZE, BLOCK_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_valid,
    input  logic [ADDRESS_WIDTH-1:0] miss_addr,
    input  logic                     flush,
    output logic                     miss_ready,
    output logic                     mem_rd,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    input  logic [7:0]               mem_din,
    output logic                     fill_we,
    output logic [INDEX_WIDTH-1:0]   fill_index,
    output logic [TAG_WIDTH-1:0]     fill_tag,
    output logic [BLOCK_SIZE*8-1:0]  fill_data
);

    localparam int unsigned LINE_ADDR_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int unsigned LINE_BITS       = BLOCK_SIZE * 8;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BYTE = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    refill_state_e              state_q, state_d;
    logic [OFFSET_WIDTH-1:0]    cnt_q, cnt_d;
    logic [LINE_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [LINE_BITS-1:0]       line_q, line_d;
    logic                       miss_ready_d;
    logic                       mem_rd_d;
    logic [ADDRESS_WIDTH-1:0]   mem_a_d;
    logic                       fill_we_q, fill_we_d;
    logic                       unused_offset;

    // Offset bits of the miss address are discarded: refills always start at the line base.
    assign unused_offset = ^miss_addr[OFFSET_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
            miss_ready  <= 1'b1;
            mem_rd      <= 1'b0;
            mem_a       <= '0;
            fill_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
            miss_ready  <= miss_ready_d;
            mem_rd      <= mem_rd_d;
            mem_a       <= mem_a_d;
            fill_we_q   <= fill_we_d;
        end
    end

    // Next state and datapath; read data trails its address by one cycle, hence DRAIN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        line_d      = line_q;

        unique case (state_q)
            ST_IDLE: begin
                if (miss_valid && !flush) begin
                    state_d     = ST_FETCH;
                    line_addr_d = miss_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
                    cnt_d       = '0;
                end
            end
            ST_FETCH: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q != '0) begin
                        line_d[{cnt_q - 1'b1, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    line_d[{LAST_BYTE, 3'b000} +: 8] = mem_din;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Offset comes straight from cnt, so the address never carries into index/tag.
        miss_ready_d = (state_d == ST_IDLE);
        mem_rd_d     = (state_d == ST_FETCH);
        mem_a_d      = mem_rd_d ? {line_addr_d, cnt_d} : mem_a;
        fill_we_d    = (state_d == ST_FILL);
    end

    assign fill_we    = fill_we_q & ~flush;
    assign fill_index = line_addr_q[INDEX_WIDTH-1:0];
    assign fill_tag   = line_addr_q[LINE_ADDR_WIDTH-1 -: TAG_WIDTH];
    assign fill_data  = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: driver pushes expected line fills, a
// negedge monitor pops and compares them and audits the memory read sequence.
module tb_icache_refill;

    localparam int unsigned CS = 1024;
    localparam int unsigned BS = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = $clog2(CS / BS);
    localparam int unsigned TW = AW - $clog2(BS) - IW;

    typedef struct {
        logic [31:0]     base;
        logic [IW-1:0]   index;
        logic [TW-1:0]   tag;
        logic [BS*8-1:0] data;
        int unsigned     edge_n;
    } fill_t;

    typedef struct {
        logic [31:0] a;
        int unsigned e;
    } rd_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            miss_valid = 1'b0;
    logic [AW-1:0]   miss_addr = '0;
    logic            flush = 1'b0;
    logic            miss_ready;
    logic            mem_rd;
    logic [AW-1:0]   mem_a;
    logic [7:0]      mem_din = 8'h00;
    logic            fill_we;
    logic [IW-1:0]   fill_index;
    logic [TW-1:0]   fill_tag;
    logic [BS*8-1:0] fill_data;

    int unsigned cyc = 0;
    int unsigned next_free = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mem_mode = 1'b0;
    fill_t       exp_q[$];
    rd_t         rd_log[$];

    icache_refill #(
        .CACHE_SIZE    (CS),
        .BLOCK_SIZE    (BS),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .flush      (flush),
        .miss_ready (miss_ready),
        .mem_rd     (mem_rd),
        .mem_a      (mem_a),
        .mem_din    (mem_din),
        .fill_we    (fill_we),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory content: mode 0 returns the low address byte, mode 1 a scrambled byte.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (!mem_mode) return a[7:0];
        return a[7:0] ^ a[15:8] ^ (a[23:16] + a[31:24]) ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_din <= mem_byte(mem_a);
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected line for a miss accepted on edge acc: fill_we is the (BS+2)th cycle
    // after that edge, i.e. the cycle that follows edge acc+BS+1.
    function automatic fill_t model_fill(input logic [31:0] addr, input int unsigned acc);
        fill_t r;
        r.base  = addr - (addr % BS);
        r.index = IW'((addr / BS) % (CS / BS));
        r.tag   = TW'(addr / CS);
        for (int i = 0; i < BS; i++) r.data[8*i +: 8] = mem_byte(r.base + 32'(i));
        r.edge_n = acc + BS + 1;
        return r;
    endfunction

    // Monitor: compare each fill against the scoreboard and the reads that produced it.
    always @(negedge clk) begin
        fill_t e;
        logic  rd_ok;
        rd_t   r;
        if (rst_n) begin
            if (mem_rd) rd_log.push_back(rd_t'{a: mem_a, e: cyc});
            if (fill_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fill", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("fill_index", 128'(fill_index), 128'(e.index));
                    check("fill_tag", 128'(fill_tag), 128'(e.tag));
                    check("fill_data", 128'(fill_data), 128'(e.data));
                    check("fill_edge", 128'(cyc), 128'(e.edge_n));
                    rd_ok = (rd_log.size() >= BS);
                    if (rd_ok) begin
                        for (int i = 0; i < BS; i++) begin
                            r = rd_log[rd_log.size() - BS + i];
                            if (r.a != e.base + 32'(i) || r.e != e.edge_n - BS - 1 + 32'(i)) rd_ok = 1'b0;
                        end
                    end
                    check("read_sequence", 128'(rd_ok), 128'(1));
                    rd_log.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_miss(input logic [31:0] addr, input bit expect_fill, output int unsigned acc);
        int unsigned req_edge, exp_acc, waited;
        bit accepted;
        req_edge = cyc + 1;
        exp_acc  = (req_edge > next_free) ? req_edge : next_free;
        waited   = 0;
        accepted = 1'b0;
        miss_addr  = addr;
        miss_valid = 1'b1;
        while (!accepted && waited < 64) begin
            if (miss_ready && !flush) accepted = 1'b1;
            tick();
            waited++;
        end
        miss_valid = 1'b0;
        acc = cyc;
        if (!accepted) begin
            check("accept_timeout", 128'(0), 128'(1));
            next_free = cyc;
        end else begin
            check("accept_edge", 128'(acc), 128'(exp_acc));
            next_free = acc + BS + 3;
            if (expect_fill) exp_q.push_back(model_fill(addr, acc));
        end
    endtask

    task automatic wait_fills_done();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"}, 128'(miss_ready), 128'(1));
        check({tag, "_mem_rd"}, 128'(mem_rd), 128'(0));
        check({tag, "_mem_a"}, 128'(mem_a), 128'(0));
        check({tag, "_fill_we"}, 128'(fill_we), 128'(0));
        check({tag, "_fill_index"}, 128'(fill_index), 128'(0));
        check({tag, "_fill_tag"}, 128'(fill_tag), 128'(0));
        check({tag, "_fill_data"}, 128'(fill_data), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, acc1, acc2;

        // Power-on reset
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_free = cyc;
        tick();

        // Default-geometry example line and top-of-memory line
        mem_mode = 1'b0;
        issue_miss(32'h0000_1234, 1'b1, acc);
        wait_fills_done();
        issue_miss(32'hFFFF_FFF8, 1'b1, acc);
        wait_fills_done();

        // Requester holds miss_valid: second miss waits out the whole first refill
        mem_mode = 1'b1;
        issue_miss(32'h0001_2A47, 1'b1, acc1);
        issue_miss(32'h8765_4321, 1'b1, acc2);
        check("b2b_spacing", 128'(acc2 - acc1), 128'(BS + 3));
        wait_fills_done();

        // Flush in the fifth FETCH cycle, then a normal miss
        issue_miss(32'h0000_5550, 1'b0, acc);
        repeat (4) tick();
        check("fetch_rd_before_flush", 128'(mem_rd), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fetch_mem_rd", 128'(mem_rd), 128'(0));
        check("flush_fetch_ready", 128'(miss_ready), 128'(1));
        check("flush_fetch_fill_we", 128'(fill_we), 128'(0));
        next_free = cyc;
        issue_miss(32'h0000_5554, 1'b1, acc);
        wait_fills_done();

        // Flush landing on the FILL cycle
        issue_miss(32'h00AB_CDE0, 1'b0, acc);
        repeat (BS + 1) tick();
        flush = 1'b1;
        #1 check("flush_fill_we", 128'(fill_we), 128'(0));
        tick();
        flush = 1'b0;
        check("flush_fill_ready", 128'(miss_ready), 128'(1));
        next_free = cyc;
        tick();

        // Asynchronous reset between edges during FETCH
        issue_miss(32'h0F0F_0F0F, 1'b0, acc);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midfetch");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_free = cyc;
        repeat (BS + 4) tick();

        // Randomised misses with random gaps, some arriving while busy
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            issue_miss($urandom(), 1'b1, acc);
        end
        wait_fills_done();

        check("pending_fills", 128'(exp_q.size()), 128'(0));
        check("stray_reads", 128'(rd_log.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL take parameter CACHE_SIZE, default 1024, cache capacity in bytes.
REQ-002 SHALL take parameter BLOCK_SIZE, default 16, line size in bytes, power of two, ≥4.
REQ-003 SHALL take parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state changes on rising edge.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have miss_valid  in  1  cache miss request.
REQ-007 SHALL have miss_addr  in  ADDRESS_WIDTH  missing fetch address, any alignment.
REQ-008 SHALL have flush  in  1  abort any refill in progress.
REQ-009 SHALL have miss_ready  out  1  high only in IDLE.
REQ-010 SHALL have mem_rd  out  1  byte read strobe.
REQ-011 SHALL have mem_a  out  ADDRESS_WIDTH  byte read address.
REQ-012 SHALL have mem_din  in  8  read byte, valid the cycle after its mem_a/mem_rd.
REQ-013 SHALL have fill_we  out  1  one-cycle line write strobe to the cache.
REQ-014 SHALL have fill_index  out  INDEX_WIDTH  target line index.
REQ-015 SHALL have fill_tag  out  TAG_WIDTH  target tag.
REQ-016 SHALL have fill_data  out  BLOCK_SIZE*8  assembled line; byte i at bits [8i+7:8i].

Function
REQ-017 SHALL derive OFFSET_WIDTH=log2(BLOCK_SIZE), INDEX_WIDTH=log2(CACHE_SIZE/BLOCK_SIZE), TAG_WIDTH=ADDRESS_WIDTH-OFFSET_WIDTH-INDEX_WIDTH.
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN, FILL.
REQ-019 SHALL accept a miss on an edge with miss_valid=1, miss_ready=1, flush=0: latch base = miss_addr with offset bits cleared; latch index and tag from miss_addr; cnt<=0; go FETCH.
REQ-020 In FETCH SHALL drive mem_rd=1, mem_a=base+cnt; increment cnt each cycle; after cnt=BLOCK_SIZE-1 go DRAIN.
REQ-021 SHALL capture mem_din into byte cnt-1 on each FETCH edge with cnt>0, and into byte BLOCK_SIZE-1 on the DRAIN edge; DRAIN goes to FILL.
REQ-022 In FILL SHALL drive fill_we=1 and stable fill_index/fill_tag/fill_data, then return to IDLE.
REQ-023 Latency: fill_we SHALL be high exactly BLOCK_SIZE+2 cycles after the accepting edge (18 for default).
REQ-024 mem_rd SHALL be 0 outside FETCH; mem_a holds last value outside FETCH.
REQ-025 base+cnt SHALL never carry out of the offset field (addresses stay within the line, no wrap into tag/index).
REQ-026 flush in FETCH/DRAIN/FILL SHALL force IDLE on the next edge; fill_we SHALL be 0 in any cycle flush=1.
REQ-027 flush=1 with miss_valid=1 in IDLE SHALL not accept the miss.
REQ-028 miss_valid outside IDLE SHALL be ignored; requester holds it until accepted.
REQ-029 A new miss SHALL be acceptable the cycle after FILL (back-to-back period BLOCK_SIZE+3 cycles).

Reset
REQ-030 On rst_n=0, immediately and regardless of clk: state=IDLE, cnt=0, miss_ready=1, mem_rd=0, mem_a=0, fill_we=0, fill_index=0, fill_tag=0, fill_data=0.
REQ-031 Reset mid-refill SHALL discard the partial line; no fill_we is produced for it.

Structure
REQ-032 Shared package SHALL hold cache geometry constants (OFFSET_WIDTH, INDEX_WIDTH, TAG_WIDTH derivation) common with the instruction cache, plus the refill FSM state encoding.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 Defaults, miss_addr=0x00001234, memory returns low address byte -> mem_a 0x1230..0x123F, fill_index=0x23, fill_tag=0x4, fill_data=0x3F3E...3130, fill_we high at cycle 18.
REQ-035 flush at cycle 5 of FETCH -> mem_rd=0 next cycle, no fill_we, miss_ready=1; following miss completes normally.
REQ-036 flush coincident with FILL -> fill_we stays 0; state IDLE next cycle.
REQ-037 rst_n low mid-FETCH between clock edges -> all outputs at reset values immediately; no fill_we after release.
REQ-038 miss_valid held high, two addresses -> second accepted exactly 19 cycles after first; two fill_we pulses, correct data each.
REQ-039 miss_addr=0xFFFFFFF8 -> mem_a 0xFFFFFFF0..0xFFFFFFFF, fill_index=0x3F, fill_tag=0x3FFFFF, no address wrap.
